// File: rtl/isoiec7816_atr_controller.sv
// ISO/IEC 7816 Answer-To-Reset sequencer.
// Enables the character receiver after card reset, resolves the convention
// from TS and walks the ATR structure (T0, interface groups, historical bytes,
// TCK), reporting each byte and the parsed protocol/TA1 to the host.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | receiver off, waiting for start
// WAIT_TS | receiver on, waiting for the initial character
// T0      | waiting for the format byte (Y1 mask, K)
// IFACE   | consuming TAi/TBi/TCi/TDi as selected by the current mask
// HIST    | consuming K historical bytes
// TCK     | waiting for the check byte
// DONE    | ATR complete; receiver left running for the protocol layer
// ERROR   | ATR failed; receiver off, error_code holds the cause
module isoiec7816_atr_controller #(
   parameter logic [10:0] DEFAULT_ETU  = 11'd371,
   parameter logic [23:0] TS_TIMEOUT   = 24'd40000,
   parameter logic [23:0] CHAR_TIMEOUT = 24'd3571200,
   parameter logic [5:0]  MAX_ATR_LEN  = 6'd33
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_char,
   input  logic        rx_received,
   output logic        rx_enable,
   output logic        inverse,
   output logic [10:0] etu,
   output logic [7:0]  atr_byte,
   output logic        atr_byte_valid,
   output logic [5:0]  atr_index,
   output logic        busy,
   output logic        atr_done,
   output logic        atr_error,
   output logic [2:0]  error_code,
   output logic [3:0]  protocol,
   output logic [7:0]  ta1,
   output logic [3:0]  hist_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_TS, S_T0, S_IFACE, S_HIST, S_TCK, S_DONE, S_ERROR
   } state_t;

   state_t      state;
   state_t      byte_state;
   logic [23:0] tmo_cnt;
   logic [23:0] tmo_lim;
   logic [7:0]  acc;
   logic [3:0]  mask;
   logic [3:0]  mask_nxt;
   logic [3:0]  hist_left;
   logic [4:0]  group;
   logic [5:0]  idx;
   logic [1:0]  lsb;
   logic        tck_required;
   logic        tck_nxt;
   logic        timing;
   logic        timed_out;
   logic        ts_bad;
   logic        too_long;

   assign etu = DEFAULT_ETU;

   // Decode what the byte arriving this cycle would do to the parse.
   always_comb begin
      lsb = 2'd3;
      if (mask[0])      lsb = 2'd0;
      else if (mask[1]) lsb = 2'd1;
      else if (mask[2]) lsb = 2'd2;
      mask_nxt = mask & ~(4'b0001 << lsb);
      if (lsb == 2'd3) mask_nxt = rx_char[7:4];
      tck_nxt = tck_required | ((lsb == 2'd3) && (rx_char[3:0] != 4'd0));
      timing = (state == S_WAIT_TS) || (state == S_T0) || (state == S_IFACE) ||
               (state == S_HIST) || (state == S_TCK);
      tmo_lim = (state == S_WAIT_TS) ? TS_TIMEOUT : CHAR_TIMEOUT;
      timed_out = timing && !rx_received && ((tmo_cnt + 24'd1) == tmo_lim);
      byte_state = state;
      case (state)
         S_WAIT_TS: byte_state = ((rx_char == 8'h3B) || (rx_char == 8'h03)) ? S_T0 : S_ERROR;
         S_T0: begin
            if (rx_char[7:4] != 4'd0)      byte_state = S_IFACE;
            else if (rx_char[3:0] != 4'd0) byte_state = S_HIST;
            else                           byte_state = S_DONE;
         end
         S_IFACE: begin
            if (mask_nxt != 4'd0)        byte_state = S_IFACE;
            else if (hist_count != 4'd0) byte_state = S_HIST;
            else if (tck_nxt)            byte_state = S_TCK;
            else                         byte_state = S_DONE;
         end
         S_HIST: begin
            if (hist_left != 4'd1) byte_state = S_HIST;
            else if (tck_required) byte_state = S_TCK;
            else                   byte_state = S_DONE;
         end
         S_TCK: byte_state = ((acc ^ rx_char) == 8'h00) ? S_DONE : S_ERROR;
         default: byte_state = state;
      endcase
      ts_bad = (state == S_WAIT_TS) && (byte_state == S_ERROR);
      too_long = (idx == (MAX_ATR_LEN - 6'd1)) && (byte_state != S_DONE) &&
                 (byte_state != S_ERROR);
   end

   // Sequencer: start restarts from any state, bytes advance the parse,
   // silence beyond the active limit aborts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         rx_enable      <= 1'b0;
         inverse        <= 1'b0;
         atr_byte       <= 8'h00;
         atr_byte_valid <= 1'b0;
         atr_index      <= 6'd0;
         busy           <= 1'b0;
         atr_done       <= 1'b0;
         atr_error      <= 1'b0;
         error_code     <= 3'd0;
         protocol       <= 4'd0;
         ta1            <= 8'h11;
         hist_count     <= 4'd0;
         tmo_cnt        <= 24'd0;
         acc            <= 8'h00;
         mask           <= 4'd0;
         hist_left      <= 4'd0;
         group          <= 5'd0;
         idx            <= 6'd0;
         tck_required   <= 1'b0;
      end else begin
         atr_byte_valid <= 1'b0;
         if (start) begin
            state        <= S_WAIT_TS;
            rx_enable    <= 1'b1;
            inverse      <= 1'b0;
            busy         <= 1'b1;
            atr_done     <= 1'b0;
            atr_error    <= 1'b0;
            error_code   <= 3'd0;
            atr_index    <= 6'd0;
            idx          <= 6'd0;
            protocol     <= 4'd0;
            hist_count   <= 4'd0;
            ta1          <= 8'h11;
            tmo_cnt      <= 24'd0;
            acc          <= 8'h00;
            tck_required <= 1'b0;
         end else if (timing && rx_received) begin
            tmo_cnt <= 24'd0;
            if (ts_bad) begin
               state      <= S_ERROR;
               atr_error  <= 1'b1;
               error_code <= 3'd1;
               busy       <= 1'b0;
               rx_enable  <= 1'b0;
            end else begin
               atr_byte_valid <= 1'b1;
               atr_byte       <= (state == S_WAIT_TS && rx_char == 8'h03) ? 8'h3F : rx_char;
               atr_index      <= idx;
               idx            <= idx + 6'd1;
               case (state)
                  S_WAIT_TS: if (rx_char == 8'h03) inverse <= 1'b1;
                  S_T0: begin
                     mask       <= rx_char[7:4];
                     hist_count <= rx_char[3:0];
                     hist_left  <= rx_char[3:0];
                     group      <= 5'd1;
                     acc        <= rx_char;
                  end
                  S_IFACE: begin
                     acc  <= acc ^ rx_char;
                     mask <= mask_nxt;
                     if (lsb == 2'd0 && group == 5'd1) ta1 <= rx_char;
                     if (lsb == 2'd3) begin
                        group        <= group + 5'd1;
                        tck_required <= tck_nxt;
                        if (group == 5'd1) protocol <= rx_char[3:0];
                     end
                  end
                  S_HIST: begin
                     acc       <= acc ^ rx_char;
                     hist_left <= hist_left - 4'd1;
                  end
                  default: ;
               endcase
               if (too_long) begin
                  state      <= S_ERROR;
                  atr_error  <= 1'b1;
                  error_code <= 3'd4;
                  busy       <= 1'b0;
                  rx_enable  <= 1'b0;
               end else if (byte_state == S_ERROR) begin
                  state      <= S_ERROR;
                  atr_error  <= 1'b1;
                  error_code <= 3'd3;
                  busy       <= 1'b0;
                  rx_enable  <= 1'b0;
               end else begin
                  state <= byte_state;
                  if (byte_state == S_DONE) begin
                     atr_done <= 1'b1;
                     busy     <= 1'b0;
                  end
               end
            end
         end else if (timed_out) begin
            state      <= S_ERROR;
            atr_error  <= 1'b1;
            error_code <= 3'd2;
            busy       <= 1'b0;
            rx_enable  <= 1'b0;
         end else if (timing) begin
            tmo_cnt <= tmo_cnt + 24'd1;
         end
      end
   end

endmodule

// File: tb/tb_isoiec7816_atr_controller.sv
// Directed bench for the ATR sequencer. CHAR_TIMEOUT is shortened so the
// inter-character timeout can be exercised in a short run.
module tb_isoiec7816_atr_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_char = 8'h00;
   logic        rx_received = 1'b0;
   logic        rx_enable;
   logic        inverse;
   logic [10:0] etu;
   logic [7:0]  atr_byte;
   logic        atr_byte_valid;
   logic [5:0]  atr_index;
   logic        busy;
   logic        atr_done;
   logic        atr_error;
   logic [2:0]  error_code;
   logic [3:0]  protocol;
   logic [7:0]  ta1;
   logic [3:0]  hist_count;

   int total = 0;
   int bad = 0;
   logic       obs_valid;
   logic [7:0] obs_byte;
   logic [5:0] obs_idx;

   isoiec7816_atr_controller #(.CHAR_TIMEOUT(24'd1000)) dut (
      .clock(clock), .reset(reset), .start(start), .rx_char(rx_char),
      .rx_received(rx_received), .rx_enable(rx_enable), .inverse(inverse),
      .etu(etu), .atr_byte(atr_byte), .atr_byte_valid(atr_byte_valid),
      .atr_index(atr_index), .busy(busy), .atr_done(atr_done),
      .atr_error(atr_error), .error_code(error_code), .protocol(protocol),
      .ta1(ta1), .hist_count(hist_count)
   );

   always #5 clock = ~clock;

   task automatic do_start();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clock); #1 rx_char = b; rx_received = 1'b1;
      @(posedge clock); #1 rx_received = 1'b0;
      obs_valid = atr_byte_valid; obs_byte = atr_byte; obs_idx = atr_index;
   endtask

   task automatic test_reset();
      total++; if (etu !== 11'd371) begin bad++; $display("FAIL reset_etu got=%0d want=371", etu); end
      total++; if (ta1 !== 8'h11) begin bad++; $display("FAIL reset_ta1 got=%h want=11", ta1); end
      total++; if ({rx_enable, inverse, busy, atr_done, atr_error, atr_byte_valid} !== 6'b0)
         begin bad++; $display("FAIL reset_flags got=%b want=000000", {rx_enable, inverse, busy, atr_done, atr_error, atr_byte_valid}); end
      total++; if ({error_code, protocol, hist_count, atr_index, atr_byte} !== 25'd0)
         begin bad++; $display("FAIL reset_fields got=%h want=0", {error_code, protocol, hist_count, atr_index, atr_byte}); end
   endtask

   task automatic test_direct();
      do_start();
      total++; if ({busy, rx_enable, inverse} !== 3'b110) begin bad++; $display("FAIL start_flags got=%b want=110", {busy, rx_enable, inverse}); end
      send_byte(8'h3B);
      total++; if ({obs_valid, obs_byte, obs_idx} !== {1'b1, 8'h3B, 6'd0}) begin bad++; $display("FAIL direct_ts got=%b/%h/%0d want=1/3b/0", obs_valid, obs_byte, obs_idx); end
      @(posedge clock); #1;
      total++; if (atr_byte_valid !== 1'b0) begin bad++; $display("FAIL strobe_width got=%b want=0", atr_byte_valid); end
      send_byte(8'h00);
      total++; if ({obs_valid, obs_byte, obs_idx} !== {1'b1, 8'h00, 6'd1}) begin bad++; $display("FAIL direct_t0 got=%b/%h/%0d want=1/00/1", obs_valid, obs_byte, obs_idx); end
      total++; if ({atr_done, atr_error, busy, rx_enable, inverse} !== 5'b10010) begin bad++; $display("FAIL direct_done got=%b want=10010", {atr_done, atr_error, busy, rx_enable, inverse}); end
      total++; if ({protocol, hist_count, ta1} !== {4'd0, 4'd0, 8'h11}) begin bad++; $display("FAIL direct_params got=%h want=0011", {protocol, hist_count, ta1}); end
   endtask

   task automatic test_inverse();
      do_start();
      send_byte(8'h03);
      total++; if ({obs_byte, obs_idx, inverse} !== {8'h3F, 6'd0, 1'b1}) begin bad++; $display("FAIL inverse_ts got=%h/%0d/%b want=3f/0/1", obs_byte, obs_idx, inverse); end
      send_byte(8'h00);
      total++; if ({atr_done, inverse} !== 2'b11) begin bad++; $display("FAIL inverse_done got=%b want=11", {atr_done, inverse}); end
   endtask

   task automatic test_tck();
      logic [7:0] seq [4];
      seq[0] = 8'h3B; seq[1] = 8'h80; seq[2] = 8'h01; seq[3] = 8'h81;
      do_start();
      for (int i = 0; i < 4; i++) send_byte(seq[i]);
      total++; if ({atr_done, atr_error, protocol, obs_idx} !== {1'b1, 1'b0, 4'd1, 6'd3}) begin bad++; $display("FAIL tck_ok got=%b%b/%0d/%0d want=10/1/3", atr_done, atr_error, protocol, obs_idx); end
      seq[3] = 8'h80;
      do_start();
      for (int i = 0; i < 4; i++) send_byte(seq[i]);
      total++; if ({atr_done, atr_error, error_code, rx_enable, busy} !== {1'b0, 1'b1, 3'd3, 1'b0, 1'b0}) begin bad++; $display("FAIL tck_bad got=%b%b/%0d/%b%b want=01/3/00", atr_done, atr_error, error_code, rx_enable, busy); end
   endtask

   task automatic test_ta1_hist();
      logic [7:0] seq [5];
      int strobes;
      seq[0] = 8'h3B; seq[1] = 8'h12; seq[2] = 8'h96; seq[3] = 8'h41; seq[4] = 8'h42;
      strobes = 0;
      do_start();
      for (int i = 0; i < 5; i++) begin send_byte(seq[i]); if (obs_valid) strobes++; end
      total++; if ({ta1, hist_count, atr_done} !== {8'h96, 4'd2, 1'b1}) begin bad++; $display("FAIL ta1_hist got=%h/%0d/%b want=96/2/1", ta1, hist_count, atr_done); end
      total++; if (strobes !== 5 || obs_idx !== 6'd4 || obs_byte !== 8'h42) begin bad++; $display("FAIL hist_strobes got=%0d/%0d/%h want=5/4/42", strobes, obs_idx, obs_byte); end
   endtask

   task automatic test_bad_ts();
      do_start();
      send_byte(8'h55);
      total++; if ({atr_error, error_code, busy, rx_enable} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin bad++; $display("FAIL bad_ts got=%b/%0d/%b%b want=1/1/00", atr_error, error_code, busy, rx_enable); end
   endtask

   task automatic test_timeouts();
      do_start();
      repeat (39999) @(posedge clock);
      #1;
      total++; if (atr_error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ts_tmo_early got=%b%b want=01", atr_error, busy); end
      @(posedge clock); #1;
      total++; if ({atr_error, error_code} !== {1'b1, 3'd2}) begin bad++; $display("FAIL ts_tmo got=%b/%0d want=1/2", atr_error, error_code); end
      do_start();
      send_byte(8'h3B);
      repeat (999) @(posedge clock);
      #1;
      total++; if (atr_error !== 1'b0) begin bad++; $display("FAIL char_tmo_early got=%b want=0", atr_error); end
      @(posedge clock); #1;
      total++; if ({atr_error, error_code, rx_enable} !== {1'b1, 3'd2, 1'b0}) begin bad++; $display("FAIL char_tmo got=%b/%0d/%b want=1/2/0", atr_error, error_code, rx_enable); end
   endtask

   task automatic test_restart();
      do_start();
      send_byte(8'h3B); send_byte(8'h0F);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      total++; if ({busy, hist_count, obs_idx} !== {1'b1, 4'd15, 6'd9}) begin bad++; $display("FAIL mid_hist got=%b/%0d/%0d want=1/15/9", busy, hist_count, obs_idx); end
      do_start();
      total++; if ({busy, rx_enable, atr_done, atr_error, atr_index, hist_count, protocol, ta1} !== {4'b1100, 6'd0, 4'd0, 4'd0, 8'h11})
         begin bad++; $display("FAIL restart got=%b%b%b%b/%0d/%0d/%0d/%h want=1100/0/0/0/11", busy, rx_enable, atr_done, atr_error, atr_index, hist_count, protocol, ta1); end
      send_byte(8'h3B); send_byte(8'h0F);
      for (int i = 1; i <= 15; i++) send_byte(8'(8'h20 + i));
      total++; if ({atr_done, hist_count, obs_idx, obs_byte} !== {1'b1, 4'd15, 6'd16, 8'h2F}) begin bad++; $display("FAIL hist15 got=%b/%0d/%0d/%h want=1/15/16/2f", atr_done, hist_count, obs_idx, obs_byte); end
   endtask

   task automatic test_reset_mid();
      do_start();
      send_byte(8'h03); send_byte(8'h12); send_byte(8'h96); send_byte(8'h41);
      @(posedge clock); #1 reset = 1'b0;
      #2;
      total++; if ({rx_enable, inverse, busy, atr_done, atr_error, atr_byte_valid} !== 6'b0) begin bad++; $display("FAIL rst_mid_flags got=%b want=000000", {rx_enable, inverse, busy, atr_done, atr_error, atr_byte_valid}); end
      total++; if ({ta1, hist_count, atr_index, atr_byte, error_code} !== {8'h11, 4'd0, 6'd0, 8'h00, 3'd0}) begin bad++; $display("FAIL rst_mid_fields got=%h/%0d/%0d/%h/%0d want=11/0/0/00/0", ta1, hist_count, atr_index, atr_byte, error_code); end
      @(posedge clock); #1 reset = 1'b1;
   endtask

   task automatic test_too_long();
      do_start();
      send_byte(8'h3B); send_byte(8'h80);
      for (int i = 0; i < 30; i++) send_byte(8'h80);
      total++; if ({atr_error, busy, obs_idx} !== {1'b0, 1'b1, 6'd31}) begin bad++; $display("FAIL len32 got=%b%b/%0d want=01/31", atr_error, busy, obs_idx); end
      send_byte(8'h80);
      total++; if ({atr_error, error_code, obs_idx} !== {1'b1, 3'd4, 6'd32}) begin bad++; $display("FAIL len33 got=%b/%0d/%0d want=1/4/32", atr_error, error_code, obs_idx); end
   endtask

   task automatic test_start_priority();
      do_start();
      send_byte(8'h3B);
      @(posedge clock); #1 start = 1'b1; rx_char = 8'h00; rx_received = 1'b1;
      @(posedge clock); #1 start = 1'b0; rx_received = 1'b0;
      total++; if ({atr_done, busy, atr_byte_valid, atr_index} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin bad++; $display("FAIL start_prio got=%b%b%b/%0d want=010/0", atr_done, busy, atr_byte_valid, atr_index); end
   endtask

   initial begin
      #12;
      test_reset();
      reset = 1'b1;
      test_direct();
      test_inverse();
      test_tck();
      test_ta1_hist();
      test_bad_ts();
      test_timeouts();
      test_restart();
      test_reset_mid();
      test_too_long();
      test_start_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
